// File: rtl/alnpc_ram_pkg.sv
// Shared types and address helpers for the partitioned active-list next-PC RAM.
package alnpc_ram_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        INIT  = 2'b01,
        READY = 2'b10
    } part_state_t;

    // Partition number from the top plog bits of an index-wide address.
    function automatic logic [31:0] addr_part(input logic [31:0] addr,
                                              input int unsigned index,
                                              input int unsigned plog);
        if (plog == 0) return 32'd0;
        return (addr >> (index - plog)) & ((32'd1 << plog) - 32'd1);
    endfunction

    // Offset inside the partition: the low index-plog bits.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int unsigned index,
                                                input int unsigned plog);
        return addr & ((32'd1 << (index - plog)) - 32'd1);
    endfunction

endpackage

// File: rtl/alnpc_ram_bank.sv
// One partition: storage, scrub FSM, prioritised write ports and gated read muxes.
module alnpc_ram_bank
    import alnpc_ram_pkg::*;
#(
    parameter int unsigned RPORT    = 1,
    parameter int unsigned WPORT    = 4,
    parameter int unsigned PDEPTH   = 32,
    parameter int unsigned OFFW     = 5,
    parameter int unsigned WIDTH    = 64,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            active,
    input  logic [WPORT-1:0]                we,
    input  logic [WPORT-1:0][OFFW-1:0]      wr_offset,
    input  logic [WPORT-1:0][WIDTH-1:0]     wr_data,
    input  logic [RPORT-1:0][OFFW-1:0]      rd_offset,
    output logic [RPORT-1:0][WIDTH-1:0]     rd_data,
    output logic                            ready
);

    logic [WIDTH-1:0] mem [PDEPTH];
    part_state_t      state_q, state_d;
    logic [OFFW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= active ? INIT : OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Deactivation beats every other transition; the scrub ends on entry PDEPTH-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                if (active) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            INIT: begin
                if (!active) begin
                    state_d = OFF;
                end else begin
                    cnt_d = OFFW'(cnt_q + 1'b1);
                    if (cnt_q == OFFW'(PDEPTH - 1)) state_d = READY;
                end
            end
            READY: begin
                if (!active) state_d = OFF;
            end
            default: state_d = OFF;
        endcase
    end

    // Later ports are assigned last, so the highest-numbered port wins a collision.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= INIT_VAL;
        end else if (state_q == READY) begin
            for (int w = 0; w < int'(WPORT); w++) begin
                if (we[w]) mem[wr_offset[w]] <= wr_data[w];
            end
        end
    end

    assign ready = (state_q == READY);

    always_comb begin
        for (int r = 0; r < int'(RPORT); r++) begin
            rd_data[r] = ready ? mem[rd_offset[r]] : INIT_VAL;
        end
    end

endmodule

// File: rtl/alnpc_ram_partitioned_init.sv
// Multi-port partitioned RAM with per-partition power gating and scrub-on-activate.
module alnpc_ram_partitioned_init
    import alnpc_ram_pkg::*;
#(
    parameter int unsigned RPORT         = 1,
    parameter int unsigned WPORT         = 4,
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned INDEX         = 7,
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned NUM_PARTS     = 4,
    parameter int unsigned NUM_PARTS_LOG = 2,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [RPORT-1:0][INDEX-1:0]     addr_i,
    output logic [RPORT-1:0][WIDTH-1:0]     data_o,
    input  logic [WPORT-1:0][INDEX-1:0]     addrWr_i,
    input  logic [WPORT-1:0][WIDTH-1:0]     dataWr_i,
    input  logic [WPORT-1:0]                we_i,
    input  logic [WPORT-1:0]                laneActive_i,
    input  logic [NUM_PARTS-1:0]            partActive_i,
    output logic [NUM_PARTS-1:0]            partReady_o,
    output logic                            ramReady_o
);

    localparam int unsigned PDEPTH = DEPTH / NUM_PARTS;
    localparam int unsigned OFFW   = (INDEX > NUM_PARTS_LOG) ? INDEX - NUM_PARTS_LOG : 1;
    localparam int unsigned PW     = (NUM_PARTS_LOG > 0) ? NUM_PARTS_LOG : 1;

    logic [WPORT-1:0][PW-1:0]                   wr_part;
    logic [WPORT-1:0][OFFW-1:0]                 wr_off;
    logic [RPORT-1:0][PW-1:0]                   rd_part;
    logic [RPORT-1:0][OFFW-1:0]                 rd_off;
    logic [NUM_PARTS-1:0][RPORT-1:0][WIDTH-1:0] bank_rd;

    always_comb begin
        for (int w = 0; w < int'(WPORT); w++) begin
            wr_part[w] = PW'(addr_part(32'(addrWr_i[w]), INDEX, NUM_PARTS_LOG));
            wr_off[w]  = OFFW'(addr_offset(32'(addrWr_i[w]), INDEX, NUM_PARTS_LOG));
        end
        for (int r = 0; r < int'(RPORT); r++) begin
            rd_part[r] = PW'(addr_part(32'(addr_i[r]), INDEX, NUM_PARTS_LOG));
            rd_off[r]  = OFFW'(addr_offset(32'(addr_i[r]), INDEX, NUM_PARTS_LOG));
        end
    end

    for (genvar p = 0; p < int'(NUM_PARTS); p++) begin : g_bank
        logic [WPORT-1:0] we_p;

        always_comb begin
            for (int w = 0; w < int'(WPORT); w++) begin
                we_p[w] = we_i[w] & laneActive_i[w] & (wr_part[w] == PW'(p));
            end
        end

        alnpc_ram_bank #(
            .RPORT    (RPORT),
            .WPORT    (WPORT),
            .PDEPTH   (PDEPTH),
            .OFFW     (OFFW),
            .WIDTH    (WIDTH),
            .INIT_VAL (INIT_VAL)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .active    (partActive_i[p]),
            .we        (we_p),
            .wr_offset (wr_off),
            .wr_data   (dataWr_i),
            .rd_offset (rd_off),
            .rd_data   (bank_rd[p]),
            .ready     (partReady_o[p])
        );
    end

    always_comb begin
        for (int r = 0; r < int'(RPORT); r++) begin
            data_o[r] = INIT_VAL;
            for (int p = 0; p < int'(NUM_PARTS); p++) begin
                if (rd_part[r] == PW'(p)) data_o[r] = bank_rd[p][r];
            end
        end
    end

    // Inactive partitions never hold ramReady_o low; the reset cycle always does.
    assign ramReady_o = (&(partReady_o | ~partActive_i)) & ~reset;

endmodule

// File: tb/tb_alnpc_ram_partitioned_init.sv
// Directed bench for the partitioned RAM: DEPTH=32, 4 partitions of 8, 2 write ports.
module tb_alnpc_ram_partitioned_init;

    logic             clk = 1'b0;
    logic             reset;
    logic [0:0][4:0]  addr_i;
    logic [0:0][63:0] data_o;
    logic [1:0][4:0]  addrWr_i;
    logic [1:0][63:0] dataWr_i;
    logic [1:0]       we_i;
    logic [1:0]       laneActive_i;
    logic [3:0]       partActive_i;
    logic [3:0]       partReady_o;
    logic             ramReady_o;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    alnpc_ram_partitioned_init #(
        .RPORT         (1),
        .WPORT         (2),
        .DEPTH         (32),
        .INDEX         (5),
        .WIDTH         (64),
        .NUM_PARTS     (4),
        .NUM_PARTS_LOG (2),
        .INIT_VAL      ('0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_i       (addr_i),
        .data_o       (data_o),
        .addrWr_i     (addrWr_i),
        .dataWr_i     (dataWr_i),
        .we_i         (we_i),
        .laneActive_i (laneActive_i),
        .partActive_i (partActive_i),
        .partReady_o  (partReady_o),
        .ramReady_o   (ramReady_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [63:0] exp);
        addr_i[0] = a;
        #1;
        chk(tag, data_o[0], exp);
    endtask

    initial begin
        reset        = 1'b1;
        addr_i       = '0;
        addrWr_i     = '0;
        dataWr_i     = '0;
        we_i         = '0;
        laneActive_i = 2'b11;
        partActive_i = 4'b1111;

        // Power-on scrub: 8 cycles not ready, ready on the 9th cycle after reset.
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("boot_part_ready", 64'(partReady_o), 64'h0);
            chk("boot_ram_ready", 64'(ramReady_o), 64'h0);
            rd("boot_read", 5'(i * 4 + 3), 64'h0);
            tick();
        end
        chk("boot_done_part", 64'(partReady_o), 64'hF);
        chk("boot_done_ram", 64'(ramReady_o), 64'h1);
        rd("boot_read_31", 5'd31, 64'h0);

        // Clocked write: old data in the write cycle, new data the next.
        we_i = 2'b01; addrWr_i[0] = 5'd5; dataWr_i[0] = 64'hA5;
        rd("wr_same_cycle", 5'd5, 64'h0);
        tick();
        we_i = 2'b00;
        rd("wr_next_cycle", 5'd5, 64'hA5);

        // Same-entry collision: higher port wins, unless its lane is gated.
        we_i = 2'b11; addrWr_i[0] = 5'd12; addrWr_i[1] = 5'd12;
        dataWr_i[0] = 64'h11; dataWr_i[1] = 64'h22;
        tick();
        we_i = 2'b00;
        rd("collide_port1", 5'd12, 64'h22);
        we_i = 2'b11; laneActive_i = 2'b01;
        tick();
        we_i = 2'b00; laneActive_i = 2'b11;
        rd("lane_gated", 5'd12, 64'h11);

        // Partition 1 off for one cycle, then a full rescrub.
        partActive_i = 4'b1101;
        #1;
        chk("deact_cycle_part", 64'(partReady_o), 64'hF);
        chk("deact_cycle_ram", 64'(ramReady_o), 64'h1);
        tick();
        partActive_i = 4'b1111;
        #1;
        for (int i = 0; i < 9; i++) begin
            chk("rescrub_part", 64'(partReady_o), 64'hD);
            chk("rescrub_ram", 64'(ramReady_o), 64'h0);
            tick();
        end
        chk("rescrub_done_part", 64'(partReady_o), 64'hF);
        chk("rescrub_done_ram", 64'(ramReady_o), 64'h1);
        for (int a = 8; a < 16; a++) rd("rescrub_cleared", 5'(a), 64'h0);
        rd("other_part_kept", 5'd5, 64'hA5);

        // Write into partition 2 while it scrubs past the target offset.
        partActive_i = 4'b1011;
        tick();
        partActive_i = 4'b1111;
        tick();
        repeat (6) tick();
        we_i = 2'b01; addrWr_i[0] = 5'd20; dataWr_i[0] = 64'hDEAD;
        rd("init_read_gated", 5'd20, 64'h0);
        chk("init_part_ready", 64'(partReady_o), 64'hB);
        tick();
        we_i = 2'b00;
        tick();
        chk("init_done_part", 64'(partReady_o), 64'hF);
        rd("init_write_dropped", 5'd20, 64'h0);

        // Reset at scrub cycle 4 restarts the whole scrub.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("mid_scrub_part", 64'(partReady_o), 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rst_restart_part", 64'(partReady_o), 64'h0);
            tick();
        end
        chk("rst_restart_done", 64'(partReady_o), 64'hF);
        chk("rst_restart_ram", 64'(ramReady_o), 64'h1);

        // All partitions inactive: low only during the reset cycle.
        partActive_i = 4'b0000;
        reset = 1'b1;
        #1;
        chk("reset_cycle_ram", 64'(ramReady_o), 64'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("all_off_part", 64'(partReady_o), 64'h0);
        chk("all_off_ram", 64'(ramReady_o), 64'h1);
        rd("all_off_read", 5'd5, 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
